// File: rtl/dataflow_stream_sched_pkg.sv
// Shared types and error codes for the round-robin scheduler in front of one dataflow_stream generator.
package dataflow_stream_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_STREAM = 2'd2
    } dataflow_stream_sched_state_t;

    localparam logic [15:0] RT_DATAFLOW_STREAM_SCHED_ZERO_STEP     = 16'h0A01;
    localparam logic [15:0] RT_DATAFLOW_STREAM_SCHED_STRAY_OUTPUT  = 16'h0A02;

endpackage

// File: rtl/dataflow_stream_sched_if.sv
// Requester, generator and consumer handshake bundle; master is the scheduler, slave is the surrounding fabric.
interface dataflow_stream_sched_if #(
    parameter int WIDTH   = 32,
    parameter int NUM_REQ = 4
) ();

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_start;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_step;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_bound;

    logic             gen_start_valid, gen_step_valid, gen_bound_valid;
    logic             gen_start_ready, gen_step_ready, gen_bound_ready;
    logic [WIDTH-1:0] gen_start_data,  gen_step_data,  gen_bound_data;

    logic             gen_index_valid, gen_cont_valid;
    logic             gen_index_ready, gen_cont_ready;
    logic [WIDTH-1:0] gen_index_data;
    logic             gen_cont_data;

    logic [NUM_REQ-1:0] out_index_valid, out_cont_valid;
    logic [NUM_REQ-1:0] out_index_ready, out_cont_ready;
    logic [WIDTH-1:0]   out_index_data;
    logic               out_cont_data;

    modport master (
        input  req_valid, req_start, req_step, req_bound,
        output req_ready,
        output gen_start_valid, gen_step_valid, gen_bound_valid,
        output gen_start_data, gen_step_data, gen_bound_data,
        input  gen_start_ready, gen_step_ready, gen_bound_ready,
        input  gen_index_valid, gen_cont_valid, gen_index_data, gen_cont_data,
        output gen_index_ready, gen_cont_ready,
        output out_index_valid, out_cont_valid, out_index_data, out_cont_data,
        input  out_index_ready, out_cont_ready
    );

    modport slave (
        output req_valid, req_start, req_step, req_bound,
        input  req_ready,
        input  gen_start_valid, gen_step_valid, gen_bound_valid,
        input  gen_start_data, gen_step_data, gen_bound_data,
        output gen_start_ready, gen_step_ready, gen_bound_ready,
        output gen_index_valid, gen_cont_valid, gen_index_data, gen_cont_data,
        input  gen_index_ready, gen_cont_ready,
        input  out_index_valid, out_cont_valid, out_index_data, out_cont_data,
        output out_index_ready, out_cont_ready
    );

endinterface

// File: rtl/fabric_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above ptr, wrapping around.
module fabric_rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int GID_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [GID_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant_onehot,
    output logic [GID_W-1:0]   grant_id,
    output logic               any
);

    logic [GID_W-1:0] v_cand;

    // NOTE: every output gets a default before the search so no path leaves a value held (no latch).
    always_comb begin
        grant_onehot = '0;
        grant_id     = '0;
        any          = 1'b0;
        v_cand       = '0;
        // Walk from the farthest offset down so the nearest requester above ptr is written last.
        for (int off = NUM_REQ - 1; off >= 0; off--) begin
            v_cand = GID_W'((int'(ptr) + off) % NUM_REQ);
            if (req[v_cand]) begin
                grant_onehot         = '0;
                grant_onehot[v_cand] = 1'b1;
                grant_id             = v_cand;
                any                  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dataflow_stream_sched.sv
// Time-shares one dataflow_stream generator among NUM_REQ requesters; one loop per grant, round-robin.
module dataflow_stream_sched
    import dataflow_stream_sched_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NUM_REQ = 4,
    localparam int GID_W   = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    dataflow_stream_sched_if.master bus,
    output logic [GID_W-1:0]        grant_id,
    output logic                    busy,
    output logic                    error_valid,
    output logic [15:0]             error_code
);

    dataflow_stream_sched_state_t r_state;
    logic [GID_W-1:0] r_rr_ptr;
    logic [GID_W-1:0] r_grant_id;
    logic [WIDTH-1:0] r_saved_start, r_saved_step, r_saved_bound;
    logic             r_issue_valid;
    logic             r_busy;
    logic             r_error_valid;
    logic [15:0]      r_error_code;

    logic [NUM_REQ-1:0] w_arb_onehot;
    logic [GID_W-1:0]   w_arb_id;
    logic [GID_W-1:0]   w_ptr_next;
    logic               w_arb_any;
    logic               w_can_accept;
    logic               w_accept;
    logic               w_zero_step;
    logic               w_zero_accept;
    logic               w_issue_fire;
    logic               w_last_fire;
    logic               w_stray;

    fabric_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req          (bus.req_valid),
        .ptr          (r_rr_ptr),
        .grant_onehot (w_arb_onehot),
        .grant_id     (w_arb_id),
        .any          (w_arb_any)
    );

    // rst_n gates acceptance so req_ready reads 0 while reset is held.
    assign w_can_accept  = rst_n && (r_state == S_IDLE);
    assign bus.req_ready = w_can_accept ? w_arb_onehot : '0;
    assign w_accept      = w_can_accept && w_arb_any;
    assign w_zero_step   = (bus.req_step[w_arb_id] == '0);
    assign w_zero_accept = w_accept && w_zero_step;
    assign w_ptr_next    = (w_arb_id == GID_W'(NUM_REQ - 1)) ? '0 : w_arb_id + 1'b1;

    assign w_issue_fire = r_issue_valid && bus.gen_start_ready && bus.gen_step_ready && bus.gen_bound_ready;
    assign w_last_fire  = (r_state == S_STREAM)
                        && bus.gen_index_valid && bus.gen_index_ready
                        && bus.gen_cont_valid  && bus.gen_cont_ready
                        && !bus.gen_cont_data;
    assign w_stray      = (bus.gen_index_valid || bus.gen_cont_valid) && (r_state != S_STREAM);

    assign bus.gen_start_valid = r_issue_valid;
    assign bus.gen_step_valid  = r_issue_valid;
    assign bus.gen_bound_valid = r_issue_valid;
    assign bus.gen_start_data  = r_saved_start;
    assign bus.gen_step_data   = r_saved_step;
    assign bus.gen_bound_data  = r_saved_bound;

    assign bus.out_index_data = bus.gen_index_data;
    assign bus.out_cont_data  = bus.gen_cont_data;

    always_comb begin
        bus.out_index_valid = '0;
        bus.out_cont_valid  = '0;
        bus.gen_index_ready = 1'b0;
        bus.gen_cont_ready  = 1'b0;
        if (r_state == S_STREAM) begin
            bus.out_index_valid[r_grant_id] = bus.gen_index_valid;
            bus.out_cont_valid[r_grant_id]  = bus.gen_cont_valid;
            bus.gen_index_ready             = bus.out_index_ready[r_grant_id];
            bus.gen_cont_ready              = bus.out_cont_ready[r_grant_id];
        end
    end

    // NOTE: registers use non-blocking assignments; the asynchronous reset clears them as soon as rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_rr_ptr      <= '0;
            r_grant_id    <= '0;
            r_saved_start <= '0;
            r_saved_step  <= '0;
            r_saved_bound <= '0;
            r_issue_valid <= 1'b0;
            r_busy        <= 1'b0;
            r_error_valid <= 1'b0;
            r_error_code  <= '0;
        end else begin
            // First error sticks until reset; a zero-step accept outranks a same-cycle stray output.
            if (!r_error_valid && (w_zero_accept || w_stray)) begin
                r_error_valid <= 1'b1;
                r_error_code  <= w_zero_accept ? RT_DATAFLOW_STREAM_SCHED_ZERO_STEP
                                               : RT_DATAFLOW_STREAM_SCHED_STRAY_OUTPUT;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_saved_start <= bus.req_start[w_arb_id];
                        r_saved_step  <= bus.req_step[w_arb_id];
                        r_saved_bound <= bus.req_bound[w_arb_id];
                        r_grant_id    <= w_arb_id;
                        r_rr_ptr      <= w_ptr_next;
                        // A zero step would never terminate the generator, so it is consumed here.
                        if (!w_zero_step) begin
                            r_state       <= S_ISSUE;
                            r_issue_valid <= 1'b1;
                            r_busy        <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    if (w_issue_fire) begin
                        r_state       <= S_STREAM;
                        r_issue_valid <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (w_last_fire) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state       <= S_IDLE;
                    r_issue_valid <= 1'b0;
                    r_busy        <= 1'b0;
                end
            endcase
        end
    end

    assign grant_id    = r_grant_id;
    assign busy        = r_busy;
    assign error_valid = r_error_valid;
    assign error_code  = r_error_code;

endmodule

// File: tb/tb_dataflow_stream_sched.sv
// Scoreboard bench: directed loops push expected elements; a negedge monitor pops them on each consumer handshake.
module tb_dataflow_stream_sched;
    import dataflow_stream_sched_pkg::*;

    localparam int W = 32;
    localparam int N = 4;

    typedef struct packed {
        logic [1:0]   req;
        logic [W-1:0] idx;
        logic         cont;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dataflow_stream_sched_if #(.WIDTH(W), .NUM_REQ(N)) bus ();

    logic [1:0]  grant_id;
    logic        busy;
    logic        error_valid;
    logic [15:0] error_code;

    dataflow_stream_sched #(.WIDTH(W), .NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .grant_id    (grant_id),
        .busy        (busy),
        .error_valid (error_valid),
        .error_code  (error_code)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_popped = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Generator model: inclusive bound, first element one cycle after the init fire.
    logic         g_active;
    logic [W-1:0] g_idx, g_step, g_bound;
    logic         stray;
    logic [N-1:0] cons_rdy;

    assign bus.gen_start_ready = !g_active;
    assign bus.gen_step_ready  = !g_active;
    assign bus.gen_bound_ready = !g_active;
    assign bus.gen_index_valid = g_active | stray;
    assign bus.gen_cont_valid  = g_active;
    assign bus.gen_index_data  = g_idx;
    assign bus.gen_cont_data   = (g_idx + g_step <= g_bound);
    assign bus.out_index_ready = cons_rdy;
    assign bus.out_cont_ready  = cons_rdy;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            g_active <= 1'b0;
            g_idx    <= '0;
            g_step   <= '0;
            g_bound  <= '0;
        end else if (!g_active) begin
            if (bus.gen_start_valid && bus.gen_step_valid && bus.gen_bound_valid) begin
                g_active <= 1'b1;
                g_idx    <= bus.gen_start_data;
                g_step   <= bus.gen_step_data;
                g_bound  <= bus.gen_bound_data;
            end
        end else if (bus.gen_index_ready && bus.gen_cont_ready) begin
            if (!bus.gen_cont_data) g_active <= 1'b0;
            else                    g_idx    <= g_idx + g_step;
        end
    end

    // Monitor: pops one expected element per consumer handshake.
    initial begin
        exp_t       e;
        logic [3:0] hs;
        forever begin
            @(negedge clk);
            hs = bus.out_index_valid & bus.out_index_ready;
            if (rst_n && hs != 4'b0) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_elem: got index 0x%0h on valid 0x%0h, expected none",
                             bus.out_index_data, bus.out_index_valid);
                end else begin
                    e = exp_q.pop_front();
                    check("elem_route", 64'(bus.out_index_valid), 64'(1) << e.req);
                    check("elem_cont_valid", 64'(bus.out_cont_valid), 64'(1) << e.req);
                    check("elem_index", 64'(bus.out_index_data), 64'(e.idx));
                    check("elem_cont", 64'(bus.out_cont_data), 64'(e.cont));
                end
                n_popped++;
            end
        end
    end

    task automatic push_elem(input logic [1:0] r, input logic [W-1:0] i, input logic c);
        exp_t e;
        e.req  = r;
        e.idx  = i;
        e.cont = c;
        exp_q.push_back(e);
    endtask

    task automatic push_loop(input logic [1:0] r, input logic [W-1:0] s, input logic [W-1:0] st, input int n);
        for (int k = 0; k < n; k++) push_elem(r, s + W'(k) * st, (k != n - 1));
    endtask

    task automatic set_req(input logic [1:0] r, input logic [W-1:0] s, input logic [W-1:0] st, input logic [W-1:0] b);
        bus.req_start[r] = s;
        bus.req_step[r]  = st;
        bus.req_bound[r] = b;
    endtask

    // Holds req_valid until accepted; returns #1 after the accept edge with req_valid dropped.
    task automatic submit(input logic [1:0] r, input logic [W-1:0] s, input logic [W-1:0] st, input logic [W-1:0] b);
        logic got;
        got = 1'b0;
        set_req(r, s, st, b);
        bus.req_valid[r] = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready[r]) got = 1'b1;
        end
        check("accept", 64'(got), 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid[r] = 1'b0;
    endtask

    task automatic wait_pops(input int target);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            if (n_popped >= target) break;
        end
        check("pop_timeout", 64'(n_popped >= target), 64'd1);
        #1;
    endtask

    task automatic wait_idle();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) done = 1'b1;
        end
        check("idle_timeout", 64'(done), 64'd1);
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rr_seq [4];
    int         base;
    int         nacc;

    initial begin
        rr_seq[0] = 4'b0010;
        rr_seq[1] = 4'b1000;
        rr_seq[2] = 4'b0010;
        rr_seq[3] = 4'b1000;
        rst_n         = 1'b0;
        stray         = 1'b0;
        cons_rdy      = '1;
        bus.req_valid = 4'b0001;
        bus.req_start = '0;
        bus.req_step  = '0;
        bus.req_bound = '0;

        // Reset state, with a requester already asserting valid.
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err_valid", 64'(error_valid), 64'd0);
        check("rst_err_code", 64'(error_code), 64'd0);
        check("rst_grant", 64'(grant_id), 64'd0);
        check("rst_gen_valid", 64'(bus.gen_start_valid), 64'd0);
        bus.req_valid = '0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single loop {0,1,3}: 0,1,2,3 with cont 1,1,1,0.
        push_loop(2'd0, 0, 1, 4);
        base = n_popped;
        submit(2'd0, 0, 1, 3);
        check("t1_busy_on", 64'(busy), 64'd1);
        check("t1_gen_valid", 64'(bus.gen_start_valid & bus.gen_step_valid & bus.gen_bound_valid), 64'd1);
        check("t1_gen_bound", 64'(bus.gen_bound_data), 64'd3);
        wait_pops(base + 4);
        check("t1_busy_off", 64'(busy), 64'd0);
        wait_idle();

        // Fairness: req1 and req3 held valid, 2-element loops each.
        push_loop(2'd1, 4, 1, 2);
        push_loop(2'd3, 8, 1, 2);
        push_loop(2'd1, 4, 1, 2);
        push_loop(2'd3, 8, 1, 2);
        set_req(2'd1, 4, 1, 5);
        set_req(2'd3, 8, 1, 9);
        bus.req_valid[1] = 1'b1;
        bus.req_valid[3] = 1'b1;
        nacc = 0;
        for (int i = 0; i < 400 && nacc < 4; i++) begin
            @(negedge clk);
            if ((bus.req_ready & 4'b1010) != 4'b0) begin
                check("rr_grant", 64'(bus.req_ready), 64'(rr_seq[nacc]));
                nacc++;
            end
        end
        check("rr_count", 64'(nacc), 64'd4);
        @(posedge clk);
        #1;
        bus.req_valid[1] = 1'b0;
        bus.req_valid[3] = 1'b0;
        check("rr_last_grant", 64'(grant_id), 64'd3);
        wait_idle();

        // Zero step: consumed, not issued, flagged; next request served normally.
        submit(2'd2, 0, 0, 5);
        check("zs_no_issue", 64'(bus.gen_start_valid | bus.gen_step_valid | bus.gen_bound_valid), 64'd0);
        check("zs_busy", 64'(busy), 64'd0);
        check("zs_err_valid", 64'(error_valid), 64'd1);
        check("zs_err_code", 64'(error_code), 64'(RT_DATAFLOW_STREAM_SCHED_ZERO_STEP));
        check("zs_grant", 64'(grant_id), 64'd2);
        push_loop(2'd0, 10, 2, 3);
        submit(2'd0, 10, 2, 14);
        wait_idle();
        check("zs_err_kept", 64'(error_code), 64'(RT_DATAFLOW_STREAM_SCHED_ZERO_STEP));

        // Backpressure: granted consumer stalls 3 cycles mid-stream.
        push_loop(2'd1, 100, 3, 5);
        base = n_popped;
        submit(2'd1, 100, 3, 112);
        wait_pops(base + 2);
        cons_rdy[1] = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_gen_ready", 64'(bus.gen_index_ready), 64'd0);
            check("bp_valid_onehot", 64'(bus.out_index_valid), 64'b0010);
            @(posedge clk);
        end
        #1;
        cons_rdy[1] = 1'b1;
        wait_idle();

        // Reset while index 2 of a 10-element loop is presented.
        push_elem(2'd2, 0, 1'b1);
        push_elem(2'd2, 1, 1'b1);
        base = n_popped;
        submit(2'd2, 0, 1, 9);
        wait_pops(base + 2);
        check("mr_idx2_valid", 64'(bus.out_index_valid), 64'b0100);
        check("mr_idx2_data", 64'(bus.out_index_data), 64'd2);
        rst_n = 1'b0;
        #1;
        check("mr_busy", 64'(busy), 64'd0);
        check("mr_out_valid", 64'(bus.out_index_valid | bus.out_cont_valid), 64'd0);
        check("mr_gen_ready", 64'(bus.gen_index_ready | bus.gen_cont_ready), 64'd0);
        check("mr_gen_valid", 64'(bus.gen_start_valid), 64'd0);
        check("mr_grant", 64'(grant_id), 64'd0);
        check("mr_err", 64'({error_valid, error_code}), 64'd0);
        check("mr_queue", 64'(exp_q.size()), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_loop(2'd2, 20, 1, 3);
        submit(2'd2, 20, 1, 22);
        wait_idle();

        // Stray generator output in S_IDLE, then a zero step that must not overwrite it.
        check("st_err_clear", 64'(error_valid), 64'd0);
        stray = 1'b1;
        @(posedge clk);
        #1;
        stray = 1'b0;
        check("st_err_valid", 64'(error_valid), 64'd1);
        check("st_err_code", 64'(error_code), 64'(RT_DATAFLOW_STREAM_SCHED_STRAY_OUTPUT));
        submit(2'd3, 7, 0, 9);
        check("st_err_kept", 64'(error_code), 64'(RT_DATAFLOW_STREAM_SCHED_STRAY_OUTPUT));
        check("st_zs_busy", 64'(busy), 64'd0);
        push_loop(2'd1, 5, 5, 1);
        submit(2'd1, 5, 5, 5);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
